sgmii_phy_init_ctrl: RTL and testbench

Bring-up and recovery sequencer for the SGMII GTX PHY datapath.
- Drives the PMA/PLL reset, the TX/RX user-side resets and comma-alignment enable.
- Waits on PLL lock and reset-done, and re-runs the sequence on lock loss, elastic-buffer error or timeout.
- Sits between the reset input and the GTX wrapper, replacing the fixed 4-stage reset shift register.
- Runs entirely in the local reference-clock domain; all GTX status inputs are synchronised on entry.

---
 rtl/sgmii_pkg.sv | 22 ++
 rtl/sgmii_sync_bit.sv | 24 ++
 rtl/sgmii_phy_init_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_sgmii_phy_init_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgmii_pkg.sv
// Shared types for the SGMII GTX PHY bring-up sequencer.
// Holds the state encoding, bus widths and a saturating increment helper.
package sgmii_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_PMA_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_USR_RST   = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_READY     = 3'd4
    } state_t;

    function automatic logic [RETRY_W-1:0] sat_inc(
        input logic [RETRY_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sgmii_sync_bit.sv
// Single-bit multi-flop synchroniser for asynchronous GTX status inputs.
// Ports: i_clk destination clock, i_rst async active-high clear, i_d async in, o_q synced out.
module sgmii_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/sgmii_phy_init_ctrl.sv
// Bring-up / recovery sequencer for the SGMII GTX PHY (PMA reset, PCS resets, comma align).
// In: clk_ds_i, mgt_reset, async GTX status *_a. Out: resets, encommaalign, phy_ready, retry_cnt, state_o.
module sgmii_phy_init_ctrl
    import sgmii_pkg::*;
#(
    parameter int PMA_RST_CYCLES = 16,
    parameter int USR_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int DONE_TIMEOUT   = 16384,
    parameter int SYNC_STAGES    = 2
) (
    input  logic               clk_ds_i,
    input  logic               mgt_reset,
    input  logic               pll_locked_a,
    input  logic               resetdone_a,
    input  logic               elecidle_a,
    input  logic               rxbuf_err_a,
    output logic               pma_reset,
    output logic               sgmii_txreset,
    output logic               sgmii_rxreset,
    output logic               encommaalign,
    output logic               phy_ready,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [STATE_W-1:0] state_o
);

    localparam int TMAX  = (LOCK_TIMEOUT > DONE_TIMEOUT) ?
                           LOCK_TIMEOUT : DONE_TIMEOUT;
    localparam int CNT_W = $clog2(TMAX) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LD_PMA   = cnt_t'(PMA_RST_CYCLES - 1);
    localparam cnt_t LD_PMA_0 = cnt_t'(PMA_RST_CYCLES - 2);
    localparam cnt_t LD_LOCK  = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t LD_USR   = cnt_t'(USR_RST_CYCLES - 1);
    localparam cnt_t LD_DONE  = cnt_t'(DONE_TIMEOUT - 1);

    // Reset: asynchronous assert, release aligned to clk_ds_i.
    (* ASYNC_REG = "TRUE" *) logic [1:0] r_rst_sync;
    logic w_rst;

    always_ff @(posedge clk_ds_i or posedge mgt_reset) begin
        if (mgt_reset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    logic w_lock;
    logic w_done;
    logic w_idle;
    logic w_buferr;

    sgmii_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .i_clk (clk_ds_i),
        .i_rst (w_rst),
        .i_d   (pll_locked_a),
        .o_q   (w_lock)
    );

    sgmii_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_done (
        .i_clk (clk_ds_i),
        .i_rst (w_rst),
        .i_d   (resetdone_a),
        .o_q   (w_done)
    );

    sgmii_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_idle (
        .i_clk (clk_ds_i),
        .i_rst (w_rst),
        .i_d   (elecidle_a),
        .o_q   (w_idle)
    );

    sgmii_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_buferr (
        .i_clk (clk_ds_i),
        .i_rst (w_rst),
        .i_d   (rxbuf_err_a),
        .o_q   (w_buferr)
    );

    state_t             r_state;
    state_t             w_nxt;
    logic               w_bump;
    logic               w_exp;
    cnt_t               r_cnt;
    logic               r_cnt_vld;
    logic [RETRY_W-1:0] r_retry;
    logic               r_pma;
    logic               r_usr;
    logic               r_rdy;
    logic               r_enc;

    function automatic cnt_t f_load(input state_t s);
        case (s)
            ST_PMA_RST:   f_load = LD_PMA;
            ST_WAIT_LOCK: f_load = LD_LOCK;
            ST_USR_RST:   f_load = LD_USR;
            ST_WAIT_DONE: f_load = LD_DONE;
            default:      f_load = '0;
        endcase
    endfunction

    // The counter is 0 straight out of reset, so it is not trusted
    // until the first PMA_RST cycle has loaded it.
    assign w_exp = r_cnt_vld && (r_cnt == '0);

    // Checks are ordered lock loss > buffer error > done loss > timeout.
    always_comb begin
        w_nxt  = r_state;
        w_bump = 1'b0;
        case (r_state)
            ST_PMA_RST: begin
                if (w_exp) w_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_lock) begin
                    w_nxt = ST_USR_RST;
                end else if (w_exp) begin
                    w_nxt  = ST_PMA_RST;
                    w_bump = 1'b1;
                end
            end
            ST_USR_RST: begin
                if (!w_lock) begin
                    w_nxt  = ST_PMA_RST;
                    w_bump = 1'b1;
                end else if (w_exp) begin
                    w_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!w_lock) begin
                    w_nxt  = ST_PMA_RST;
                    w_bump = 1'b1;
                end else if (w_done) begin
                    w_nxt = ST_READY;
                end else if (w_exp) begin
                    w_nxt  = ST_USR_RST;
                    w_bump = 1'b1;
                end
            end
            ST_READY: begin
                if (!w_lock) begin
                    w_nxt  = ST_PMA_RST;
                    w_bump = 1'b1;
                end else if (w_buferr || !w_done) begin
                    w_nxt  = ST_USR_RST;
                    w_bump = 1'b1;
                end
            end
            default: begin
                w_nxt = ST_PMA_RST;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change
    // together with state_o.
    always_ff @(posedge clk_ds_i or posedge w_rst) begin
        if (w_rst) begin
            r_state   <= ST_PMA_RST;
            r_cnt     <= '0;
            r_cnt_vld <= 1'b0;
            r_retry   <= '0;
            r_pma     <= 1'b1;
            r_usr     <= 1'b1;
            r_rdy     <= 1'b0;
            r_enc     <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_cnt_vld <= 1'b1;
            if (w_nxt != r_state) begin
                r_cnt <= f_load(w_nxt);
            end else if (!r_cnt_vld) begin
                // first cycle after reset already counts toward PMA_RST
                r_cnt <= LD_PMA_0;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_bump) begin
                r_retry <= sat_inc(r_retry);
            end
            r_pma <= (w_nxt == ST_PMA_RST);
            r_usr <= (w_nxt == ST_PMA_RST) ||
                     (w_nxt == ST_WAIT_LOCK) ||
                     (w_nxt == ST_USR_RST);
            r_rdy <= (w_nxt == ST_READY);
            r_enc <= (w_nxt == ST_READY) && !w_idle;
        end
    end

    assign pma_reset     = r_pma;
    assign sgmii_txreset = r_usr;
    assign sgmii_rxreset = r_usr;
    assign phy_ready     = r_rdy;
    assign encommaalign  = r_enc;
    assign retry_cnt     = r_retry;
    assign state_o       = r_state;

endmodule

// File: tb/tb_sgmii_phy_init_ctrl.sv
// Self-checking bench for sgmii_phy_init_ctrl.
// Vector table, directed corner sequences and randomized run against a cycle model.
module tb_sgmii_phy_init_ctrl;

    localparam int PMA = 16;
    localparam int USR = 8;
    localparam int LTO = 64;
    localparam int DTO = 128;
    localparam int SYN = 2;

    logic       clk       = 1'b0;
    logic       mgt_reset = 1'b0;
    logic       lk        = 1'b0;
    logic       dn        = 1'b0;
    logic       id        = 1'b0;
    logic       be        = 1'b0;
    logic       pma;
    logic       txr;
    logic       rxr;
    logic       enc;
    logic       rdy;
    logic [7:0] retry;
    logic [2:0] st;

    sgmii_phy_init_ctrl #(
        .PMA_RST_CYCLES (PMA),
        .USR_RST_CYCLES (USR),
        .LOCK_TIMEOUT   (LTO),
        .DONE_TIMEOUT   (DTO),
        .SYNC_STAGES    (SYN)
    ) dut (
        .clk_ds_i      (clk),
        .mgt_reset     (mgt_reset),
        .pll_locked_a  (lk),
        .resetdone_a   (dn),
        .elecidle_a    (id),
        .rxbuf_err_a   (be),
        .pma_reset     (pma),
        .sgmii_txreset (txr),
        .sgmii_rxreset (rxr),
        .encommaalign  (enc),
        .phy_ready     (rdy),
        .retry_cnt     (retry),
        .state_o       (st)
    );

    always #4 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase number plus cycles spent in it.
    int ms;
    int mt;
    int mretry;
    int rel;
    bit mpma;
    bit musr;
    bit mrdy;
    bit menc;
    bit ql[$];
    bit qd[$];
    bit qi[$];
    bit qb[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        ms = 0; mt = 0; mretry = 0; rel = 0;
        mpma = 1; musr = 1; mrdy = 0; menc = 0;
        ql = {}; qd = {}; qi = {}; qb = {};
        for (int i = 0; i < SYN; i++) begin
            ql.push_back(1'b0);
            qd.push_back(1'b0);
            qi.push_back(1'b0);
            qb.push_back(1'b0);
        end
    endtask

    task automatic m_step();
        bit ul, ud, ui, ub, bump;
        int ns;
        ul = ql.pop_front(); ql.push_back(lk);
        ud = qd.pop_front(); qd.push_back(dn);
        ui = qi.pop_front(); qi.push_back(id);
        ub = qb.pop_front(); qb.push_back(be);
        mt++;
        ns = ms;
        bump = 0;
        case (ms)
            0: if (mt >= PMA) ns = 1;
            1: begin
                if (ul) ns = 2;
                else if (mt >= LTO) begin ns = 0; bump = 1; end
            end
            2: begin
                if (!ul) begin ns = 0; bump = 1; end
                else if (mt >= USR) ns = 3;
            end
            3: begin
                if (!ul) begin ns = 0; bump = 1; end
                else if (ud) ns = 4;
                else if (mt >= DTO) begin ns = 2; bump = 1; end
            end
            default: begin
                if (!ul) begin ns = 0; bump = 1; end
                else if (ub || !ud) begin ns = 2; bump = 1; end
            end
        endcase
        if (bump && mretry < 255) mretry++;
        if (ns != ms) mt = 0;
        ms = ns;
        mpma = (ms == 0);
        musr = (ms <= 2);
        mrdy = (ms == 4);
        menc = (ms == 4) && !ui;
    endtask

    task automatic tick();
        @(posedge clk);
        if (mgt_reset) m_reset();
        else if (rel < 2) rel++;
        else m_step();
        @(negedge clk);
        chk("state_o", int'(st), ms);
        chk("pma_reset", int'(pma), int'(mpma));
        chk("sgmii_txreset", int'(txr), int'(musr));
        chk("sgmii_rxreset", int'(rxr), int'(musr));
        chk("phy_ready", int'(rdy), int'(mrdy));
        chk("encommaalign", int'(enc), int'(menc));
        chk("retry_cnt", int'(retry), mretry);
    endtask

    task automatic wait_state(input int s, input int budget);
        int n;
        n = 0;
        while (int'(st) != s && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (int'(st) != s) begin
            failures++;
            $display("FAIL wait_state: state %0d after %0d cycles, required %0d",
                     st, n, s);
        end
    endtask

    typedef struct {
        bit l;
        bit d;
        bit i;
        bit b;
        int cyc;
        int st;
        bit pma;
        bit rdy;
        bit enc;
        int retry;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int r0;
        int nrise;
        int last_rise;
        int n;
        bit prevp;

        tbl[0]  = '{0, 0, 0, 0, 17, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0,  1, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0,  2, 1, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0,  1, 2, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0,  7, 2, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 0,  1, 3, 0, 0, 0, 0};
        tbl[6]  = '{1, 1, 0, 0,  2, 3, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 0,  1, 4, 0, 1, 1, 0};
        tbl[8]  = '{1, 1, 1, 0,  2, 4, 0, 1, 1, 0};
        tbl[9]  = '{1, 1, 1, 0,  1, 4, 0, 1, 0, 0};
        tbl[10] = '{1, 1, 0, 0,  3, 4, 0, 1, 1, 0};
        tbl[11] = '{1, 1, 0, 1,  2, 4, 0, 1, 1, 0};
        tbl[12] = '{1, 1, 0, 0,  1, 2, 0, 0, 0, 1};
        tbl[13] = '{1, 1, 0, 0,  7, 2, 0, 0, 0, 1};
        tbl[14] = '{1, 1, 0, 0,  1, 3, 0, 0, 0, 1};
        tbl[15] = '{1, 1, 0, 0,  1, 4, 0, 1, 1, 1};
        tbl[16] = '{0, 1, 0, 0,  2, 4, 0, 1, 1, 1};
        tbl[17] = '{0, 1, 0, 0,  1, 0, 1, 0, 0, 2};

        m_reset();
        #1 mgt_reset = 1'b1;
        repeat (3) tick();
        mgt_reset = 1'b0;

        // nominal bring-up, idle gating, buffer error, lock loss
        for (int k = 0; k < 18; k++) begin
            lk = tbl[k].l;
            dn = tbl[k].d;
            id = tbl[k].i;
            be = tbl[k].b;
            repeat (tbl[k].cyc) tick();
            chk($sformatf("tbl%0d_state", k), int'(st), tbl[k].st);
            chk($sformatf("tbl%0d_pma", k), int'(pma), int'(tbl[k].pma));
            chk($sformatf("tbl%0d_ready", k), int'(rdy), int'(tbl[k].rdy));
            chk($sformatf("tbl%0d_enc", k), int'(enc), int'(tbl[k].enc));
            chk($sformatf("tbl%0d_retry", k), int'(retry), tbl[k].retry);
        end

        // lock loss together with buffer error while in WAIT_DONE
        lk = 1; dn = 0; be = 0;
        wait_state(3, 300);
        r0 = mretry;
        lk = 0; be = 1;
        repeat (2) tick();
        chk("lockloss_hold", int'(st), 3);
        tick();
        chk("lockloss_state", int'(st), 0);
        chk("lockloss_retry", int'(retry), r0 + 1);
        be = 0;

        // asynchronous reset in the middle of WAIT_DONE
        lk = 1;
        wait_state(3, 300);
        #2 mgt_reset = 1'b1;
        lk = 0;
        #1;
        chk("arst_state", int'(st), 0);
        chk("arst_pma", int'(pma), 1);
        chk("arst_tx", int'(txr), 1);
        chk("arst_rx", int'(rxr), 1);
        chk("arst_ready", int'(rdy), 0);
        chk("arst_enc", int'(enc), 0);
        chk("arst_retry", int'(retry), 0);
        m_reset();
        repeat (2) tick();
        mgt_reset = 1'b0;
        repeat (3) tick();
        chk("arst_retry_rel", int'(retry), 0);

        // lock never arrives: periodic retries and saturation
        nrise = 0;
        last_rise = 0;
        prevp = pma;
        n = 0;
        repeat (256 * (PMA + LTO) + 200) begin
            tick();
            n++;
            if (pma && !prevp) begin
                if (nrise > 0 && nrise < 4)
                    chk("retry_period", n - last_rise, PMA + LTO);
                nrise++;
                last_rise = n;
            end
            prevp = pma;
        end
        chk("retry_sat", int'(retry), 255);

        // randomized run against the model
        mgt_reset = 1'b1;
        repeat (2) tick();
        mgt_reset = 1'b0;
        lk = 1; dn = 1; id = 0; be = 0;
        repeat (4000) begin
            if ($urandom_range(199) == 0) lk = ~lk;
            if ($urandom_range(99) == 0) dn = ~dn;
            if ($urandom_range(7) == 0) id = ~id;
            be = ($urandom_range(299) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
